pifo_reg_sorter: RTL and testbench

Register-based, shift-sorted PIFO directly downstream of the rank pipe. It drains ranked {rank, meta} pairs from the rank pipe's output handshake and keeps up to DEPTH entries sorted by ascending rank. It always presents the minimum-rank entry at the head for the scheduler/dequeue logic.

---
 rtl/pifo_reg_sorter_pkg.sv | 24 ++
 rtl/pifo_reg_cell.sv | 72 +++++++
 rtl/pifo_reg_sorter.sv | 137 +++++++++++++
 tb/tb_pifo_reg_sorter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_reg_sorter_pkg.sv
// Shared definitions for the register-based PIFO sorter: default field widths,
// entry packing order and the per-cycle update operation applied to every cell.
package pifo_reg_sorter_pkg;

  localparam int unsigned PIFO_RANK_WIDTH = 16;
  localparam int unsigned PIFO_META_WIDTH = 16;

  // Update applied to the whole array in a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_INS  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_SWAP = 2'b11
  } pifo_op_e;

  // Entries travel as {rank, meta}, matching the rank pipe.
  function automatic logic [PIFO_RANK_WIDTH+PIFO_META_WIDTH-1:0] pifo_pack(
    input logic [PIFO_RANK_WIDTH-1:0] rank,
    input logic [PIFO_META_WIDTH-1:0] meta
  );
    return {rank, meta};
  endfunction

endpackage

// File: rtl/pifo_reg_cell.sv
// One slot of the shift-sorted PIFO: selects this slot's next entry from its
// own value, its neighbours, or the incoming entry, based on the thermometer.
module pifo_reg_cell
  import pifo_reg_sorter_pkg::*;
#(
  parameter int unsigned RANK_WIDTH = PIFO_RANK_WIDTH,
  parameter int unsigned META_WIDTH = PIFO_META_WIDTH,
  parameter bit          IS_HEAD    = 1'b0
) (
  input  pifo_op_e              i_op,
  input  logic                  i_own_valid,
  input  logic [RANK_WIDTH-1:0] i_own_rank,
  input  logic [META_WIDTH-1:0] i_own_meta,
  input  logic                  i_below_valid,
  input  logic [RANK_WIDTH-1:0] i_below_rank,
  input  logic [META_WIDTH-1:0] i_below_meta,
  input  logic                  i_above_valid,
  input  logic [RANK_WIDTH-1:0] i_above_rank,
  input  logic [META_WIDTH-1:0] i_above_meta,
  input  logic [RANK_WIDTH-1:0] i_new_rank,
  input  logic [META_WIDTH-1:0] i_new_meta,
  input  logic                  i_thr_below,
  input  logic                  i_thr_own,
  input  logic                  i_thr_above,
  output logic                  o_valid,
  output logic [RANK_WIDTH-1:0] o_rank,
  output logic [META_WIDTH-1:0] o_meta
);

  // Next-state selection for this slot.
  always_comb begin
    o_valid = i_own_valid;
    o_rank  = i_own_rank;
    o_meta  = i_own_meta;
    unique case (i_op)
      OP_INS: begin
        if (!i_thr_own) begin
          if (i_thr_below) begin
            o_valid = 1'b1;
            o_rank  = i_new_rank;
            o_meta  = i_new_meta;
          end else begin
            o_valid = i_below_valid;
            o_rank  = i_below_rank;
            o_meta  = i_below_meta;
          end
        end
      end
      OP_DEQ: begin
        o_valid = i_above_valid;
        o_rank  = i_above_rank;
        o_meta  = i_above_meta;
      end
      OP_SWAP: begin
        // Shift-down and shift-up cancel for entries above the insert point,
        // so they keep their own value; the head slot ignores its own thermometer
        // bit because the head entry is leaving.
        if (i_thr_above) begin
          o_valid = i_above_valid;
          o_rank  = i_above_rank;
          o_meta  = i_above_meta;
        end else if (i_thr_own || IS_HEAD) begin
          o_valid = 1'b1;
          o_rank  = i_new_rank;
          o_meta  = i_new_meta;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pifo_reg_sorter.sv
// Register-based shift-sorted PIFO: keeps up to DEPTH {rank, meta} entries in
// ascending rank order (FIFO among equal ranks) and exposes the minimum at head.
module pifo_reg_sorter
  import pifo_reg_sorter_pkg::*;
#(
  parameter int unsigned RANK_WIDTH = PIFO_RANK_WIDTH,
  parameter int unsigned META_WIDTH = PIFO_META_WIDTH,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned L2_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  up_valid,
  input  logic [RANK_WIDTH-1:0] up_rank,
  input  logic [META_WIDTH-1:0] up_meta,
  output logic                  up_remove,
  input  logic                  deq_req,
  output logic                  deq_valid,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic [L2_DEPTH:0]     count,
  output logic                  full
);

  logic                  r_valid [DEPTH];
  logic [RANK_WIDTH-1:0] r_rank  [DEPTH];
  logic [META_WIDTH-1:0] r_meta  [DEPTH];
  logic [L2_DEPTH:0]     r_count;

  logic                  w_valid_x [DEPTH+2];
  logic [RANK_WIDTH-1:0] w_rank_x  [DEPTH+2];
  logic [META_WIDTH-1:0] w_meta_x  [DEPTH+2];
  logic [DEPTH-1:0]      w_thr;
  logic [DEPTH+1:0]      w_thr_x;

  logic                  w_nxt_valid [DEPTH];
  logic [RANK_WIDTH-1:0] w_nxt_rank  [DEPTH];
  logic [META_WIDTH-1:0] w_nxt_meta  [DEPTH];

  logic     w_full;
  logic     w_deq_fire;
  logic     w_ins_fire;
  pifo_op_e w_op;

  assign w_full     = (r_count == (L2_DEPTH+1)'(DEPTH));
  assign w_deq_fire = deq_req & r_valid[0];
  assign w_ins_fire = rstn & up_valid & (~w_full | w_deq_fire);

  assign up_remove = w_ins_fire;
  assign deq_valid = r_valid[0];
  assign deq_rank  = r_rank[0];
  assign deq_meta  = r_meta[0];
  assign count     = r_count;
  assign full      = w_full;

  // Array-wide operation for this cycle.
  always_comb begin
    w_op = OP_IDLE;
    unique case ({w_deq_fire, w_ins_fire})
      2'b01:   w_op = OP_INS;
      2'b10:   w_op = OP_DEQ;
      2'b11:   w_op = OP_SWAP;
      default: w_op = OP_IDLE;
    endcase
  end

  // Padded views so every cell has a below/above neighbour; the sentinel
  // thermometer bits make slot 0 an insert point and the top slot never shift.
  assign w_valid_x[0]       = 1'b0;
  assign w_rank_x[0]        = '0;
  assign w_meta_x[0]        = '0;
  assign w_valid_x[DEPTH+1] = 1'b0;
  assign w_rank_x[DEPTH+1]  = '0;
  assign w_meta_x[DEPTH+1]  = '0;
  assign w_thr_x            = {1'b0, w_thr, 1'b1};

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    assign w_valid_x[g+1] = r_valid[g];
    assign w_rank_x[g+1]  = r_rank[g];
    assign w_meta_x[g+1]  = r_meta[g];
    assign w_thr[g]       = r_valid[g] & (r_rank[g] <= up_rank);

    pifo_reg_cell #(
      .RANK_WIDTH (RANK_WIDTH),
      .META_WIDTH (META_WIDTH),
      .IS_HEAD    (g == 0)
    ) u_cell (
      .i_op          (w_op),
      .i_own_valid   (w_valid_x[g+1]),
      .i_own_rank    (w_rank_x[g+1]),
      .i_own_meta    (w_meta_x[g+1]),
      .i_below_valid (w_valid_x[g]),
      .i_below_rank  (w_rank_x[g]),
      .i_below_meta  (w_meta_x[g]),
      .i_above_valid (w_valid_x[g+2]),
      .i_above_rank  (w_rank_x[g+2]),
      .i_above_meta  (w_meta_x[g+2]),
      .i_new_rank    (up_rank),
      .i_new_meta    (up_meta),
      .i_thr_below   (w_thr_x[g]),
      .i_thr_own     (w_thr_x[g+1]),
      .i_thr_above   (w_thr_x[g+2]),
      .o_valid       (w_nxt_valid[g]),
      .o_rank        (w_nxt_rank[g]),
      .o_meta        (w_nxt_meta[g])
    );
  end

  // Entry storage: load every slot's next state each cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_rank[i]  <= '0;
        r_meta[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= w_nxt_valid[i];
        r_rank[i]  <= w_nxt_rank[i];
        r_meta[i]  <= w_nxt_meta[i];
      end
    end
  end

  // Occupancy: moves only when exactly one of insert/dequeue fires.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (w_ins_fire && !w_deq_fire) begin
      r_count <= r_count + 1'b1;
    end else if (!w_ins_fire && w_deq_fire) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_pifo_reg_sorter.sv
// Self-checking bench for pifo_reg_sorter: a sorted reference queue predicts
// handshake/head/count, and scripted sequences push expected dequeue results.
module tb_pifo_reg_sorter;

  logic        clk;
  logic        rstn;
  logic        up_valid;
  logic [15:0] up_rank;
  logic [15:0] up_meta;
  logic        up_remove;
  logic        deq_req;
  logic        deq_valid;
  logic [15:0] deq_rank;
  logic [15:0] deq_meta;
  logic [4:0]  count;
  logic        full;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] m;
  } ent_t;

  ent_t mdl[$];    // reference contents, sorted, FIFO among equal ranks
  ent_t exp_q[$];  // scripted expected dequeue results

  int n_checks = 0;
  int n_fail   = 0;

  pifo_reg_sorter #(
    .RANK_WIDTH (16),
    .META_WIDTH (16),
    .DEPTH      (16),
    .L2_DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .up_valid  (up_valid),
    .up_rank   (up_rank),
    .up_meta   (up_meta),
    .up_remove (up_remove),
    .deq_req   (deq_req),
    .deq_valid (deq_valid),
    .deq_rank  (deq_rank),
    .deq_meta  (deq_meta),
    .count     (count),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle starting at a negedge: drive, check combinational outputs,
  // clock, update the reference, check registered outputs.
  task automatic step(input bit v, input logic [15:0] r, input logic [15:0] m, input bit dq);
    bit   exp_deq;
    bit   exp_ins;
    int   idx;
    ent_t e;
    up_valid = v;
    up_rank  = r;
    up_meta  = m;
    deq_req  = dq;
    #1;
    exp_deq = dq && (mdl.size() > 0);
    exp_ins = v && ((mdl.size() < 16) || exp_deq);
    check("up_remove", 32'(up_remove), 32'(exp_ins));
    if (exp_deq) begin
      check("deq_rank", 32'(deq_rank), 32'(mdl[0].r));
      check("deq_meta", 32'(deq_meta), 32'(mdl[0].m));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_rank", 32'(deq_rank), 32'(e.r));
        check("sb_meta", 32'(deq_meta), 32'(e.m));
      end
    end
    @(posedge clk);
    if (exp_deq) void'(mdl.pop_front());
    if (exp_ins) begin
      idx = 0;
      while (idx < mdl.size() && mdl[idx].r <= r) idx++;
      e.r = r;
      e.m = m;
      mdl.insert(idx, e);
    end
    #1;
    check("count", 32'(count), 32'(mdl.size()));
    check("full", 32'(full), 32'(mdl.size() == 16));
    check("deq_valid", 32'(deq_valid), 32'(mdl.size() > 0));
    if (mdl.size() > 0) begin
      check("head_rank", 32'(deq_rank), 32'(mdl[0].r));
      check("head_meta", 32'(deq_meta), 32'(mdl[0].m));
    end
    @(negedge clk);
    up_valid = 1'b0;
    deq_req  = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] r, input logic [15:0] m);
    ent_t e;
    e.r = r;
    e.m = m;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int guard = 0;
    while (mdl.size() > 0 && guard < 40) begin
      step(1'b0, 16'h0, 16'h0, 1'b1);
      guard++;
    end
    check("drained", 32'(count), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rstn     = 1'b0;
    up_valid = 1'b1;
    up_rank  = 16'd4;
    up_meta  = 16'd4;
    deq_req  = 1'b1;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_deq_rank", 32'(deq_rank), 32'd0);
    check("rst_deq_meta", 32'(deq_meta), 32'd0);
    check("rst_up_remove", 32'(up_remove), 32'd0);
    up_valid = 1'b0;
    deq_req  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Ordering
    step(1'b1, 16'd5, 16'hA, 1'b0);
    step(1'b1, 16'd3, 16'hB, 1'b0);
    step(1'b1, 16'd9, 16'hC, 1'b0);
    check("order_count3", 32'(count), 32'd3);
    push_exp(16'd3, 16'hB);
    push_exp(16'd5, 16'hA);
    push_exp(16'd9, 16'hC);
    drain();

    // Equal ranks keep arrival order
    step(1'b1, 16'd7, 16'h1, 1'b0);
    step(1'b1, 16'd7, 16'h2, 1'b0);
    step(1'b1, 16'd2, 16'h3, 1'b0);
    push_exp(16'd2, 16'h3);
    push_exp(16'd7, 16'h1);
    push_exp(16'd7, 16'h2);
    drain();

    // Full and backpressure
    for (int i = 0; i < 16; i++) step(1'b1, 16'd10, 16'(i), 1'b0);
    check("full_set", 32'(full), 32'd1);
    step(1'b1, 16'd1, 16'h77, 1'b0);
    check("full_hold_remove", 32'(up_remove), 32'd0);
    check("full_hold_head", 32'(deq_rank), 32'd10);
    push_exp(16'd10, 16'd0);
    step(1'b1, 16'd1, 16'h77, 1'b1);
    check("full_swap_head", 32'(deq_rank), 32'd1);
    check("full_swap_count", 32'(count), 32'd16);
    push_exp(16'd1, 16'h77);
    for (int i = 1; i < 16; i++) push_exp(16'd10, 16'(i));
    drain();

    // Simultaneous insert and dequeue
    step(1'b1, 16'd4, 16'h44, 1'b0);
    step(1'b1, 16'd8, 16'h88, 1'b0);
    push_exp(16'd4, 16'h44);
    step(1'b1, 16'd2, 16'h22, 1'b1);
    check("sim_head", 32'(deq_rank), 32'd2);
    check("sim_count", 32'(count), 32'd2);
    push_exp(16'd2, 16'h22);
    push_exp(16'd8, 16'h88);
    drain();

    // Dequeue while empty
    step(1'b0, 16'h0, 16'h0, 1'b1);
    check("empty_count", 32'(count), 32'd0);
    check("empty_valid", 32'(deq_valid), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 5; i++) step(1'b1, 16'(20 + i), 16'(i), 1'b0);
    up_valid = 1'b1;
    up_rank  = 16'd6;
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(deq_valid), 32'd0);
    check("mid_rst_remove", 32'(up_remove), 32'd0);
    mdl.delete();
    up_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    step(1'b1, 16'd3, 16'h33, 1'b0);
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_head", 32'(deq_rank), 32'd3);
    drain();

    // Random mixed traffic against the reference queue
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)), 16'(i), 1'($urandom_range(0, 2) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
